// File: rtl/mem_access_unit_pkg.sv
// Shared types for the MA-stage to psram load/store bridge.
package mem_access_unit_pkg;

  typedef enum logic [1:0] {
    SIZE_B = 2'd0,
    SIZE_H = 2'd1,
    SIZE_W = 2'd2
  } mau_size_e;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } mau_state_e;

  function automatic logic is_misaligned(input mau_size_e size, input logic [1:0] addr_lo);
    return ((size == SIZE_H) && addr_lo[0]) || ((size == SIZE_W) && (addr_lo != 2'b00));
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// 16-bit psram controller bus; master = access unit, slave = controller.
interface mem_access_unit_if #(
  parameter int MEM_ADDR_W = 22,
  parameter int BANK_W     = 1
);
  logic [BANK_W-1:0]     mem_bank_sel;
  logic [MEM_ADDR_W-1:0] mem_addr;
  logic                  mem_write_en;
  logic                  mem_read_en;
  logic [15:0]           mem_data_in;
  logic                  mem_write_high_byte;
  logic                  mem_write_low_byte;
  logic                  mem_busy;
  logic                  mem_read_avail;
  logic [15:0]           mem_data_out;

  modport master (
    output mem_bank_sel, mem_addr, mem_write_en, mem_read_en, mem_data_in,
           mem_write_high_byte, mem_write_low_byte,
    input  mem_busy, mem_read_avail, mem_data_out
  );

  modport slave (
    input  mem_bank_sel, mem_addr, mem_write_en, mem_read_en, mem_data_in,
           mem_write_high_byte, mem_write_low_byte,
    output mem_busy, mem_read_avail, mem_data_out
  );
endinterface

// File: rtl/mem_access_unit_load_format.sv
// Combinational load-data formatter: byte/half selection, sign/zero extension, word assembly.
module mau_load_format
  import mem_access_unit_pkg::*;
(
  input  mau_size_e   size_i,
  input  logic        unsigned_i,
  input  logic        addr0_i,
  input  logic [15:0] lo_half_i,
  input  logic [15:0] data_i,
  output logic [31:0] rdata_o
);
  logic [7:0] byte_sel;

  always_comb begin
    byte_sel = addr0_i ? data_i[15:8] : data_i[7:0];
    rdata_o  = '0;
    case (size_i)
      SIZE_B:  rdata_o = {{24{~unsigned_i & byte_sel[7]}}, byte_sel};
      SIZE_H:  rdata_o = {{16{~unsigned_i & data_i[15]}}, data_i};
      default: rdata_o = {data_i, lo_half_i};
    endcase
  end
endmodule

// File: rtl/mem_access_unit.sv
// Load/store bridge from the MA stage to a 16-bit psram controller; words go out as two beats.
// Optional wait-state watchdog enabled by defining MAU_TIMEOUT_EN.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int MEM_ADDR_W     = 22,
  parameter int BANKS          = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  mem_access_unit_if.master mem
);
  localparam int BANK_W = (BANKS > 1) ? $clog2(BANKS) : 1;

  mau_state_e  state_q, state_d;
  mau_size_e   size_q, size_d;
  logic        beat_q, beat_d;
  logic        we_q, we_d;
  logic        uns_q, uns_d;
  logic        err_q, err_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [15:0] lo_q, lo_d;
  logic [31:0] fmt_rdata;
  logic        beat_done;
  logic        unused_addr;

  assign unused_addr = ^addr_q[31:MEM_ADDR_W+1+BANK_W];

  mau_load_format u_load_format (
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .addr0_i    (addr_q[0]),
    .lo_half_i  (lo_q),
    .data_i     (mem.mem_data_out),
    .rdata_o    (fmt_rdata)
  );

  // Aligned words start on an even 16-bit address, so adding the beat never carries.
  assign mem.mem_addr     = addr_q[MEM_ADDR_W:1] + MEM_ADDR_W'(beat_q);
  assign mem.mem_bank_sel = addr_q[MEM_ADDR_W+1 +: BANK_W];

  always_comb begin
    mem.mem_data_in         = wdata_q[15:0];
    mem.mem_write_high_byte = 1'b1;
    mem.mem_write_low_byte  = 1'b1;
    case (size_q)
      SIZE_B: begin
        mem.mem_data_in         = {wdata_q[7:0], wdata_q[7:0]};
        mem.mem_write_high_byte = addr_q[0];
        mem.mem_write_low_byte  = ~addr_q[0];
      end
      SIZE_W:  if (beat_q) mem.mem_data_in = wdata_q[31:16];
      default: ;
    endcase
  end

`ifdef MAU_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             tmo_hit;

  assign tmo_hit = ((state_q == ISSUE) || (state_q == WAIT)) &&
                   (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    tmo_cnt_d = '0;
    if ((state_d == state_q) && ((state_q == ISSUE) || (state_q == WAIT)))
      tmo_cnt_d = tmo_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) tmo_cnt_q <= '0;
    else       tmo_cnt_q <= tmo_cnt_d;
  end
`endif

  always_comb begin
    state_d          = state_q;
    size_d           = size_q;
    beat_d           = beat_q;
    we_d             = we_q;
    uns_d            = uns_q;
    err_d            = err_q;
    addr_d           = addr_q;
    wdata_d          = wdata_q;
    rdata_d          = rdata_q;
    lo_d             = lo_q;
    beat_done        = 1'b0;
    mem.mem_write_en = 1'b0;
    mem.mem_read_en  = 1'b0;
    case (state_q)
      IDLE: if (req_valid) begin
        size_d  = mau_size_e'(req_size);
        we_d    = req_we;
        uns_d   = req_unsigned;
        addr_d  = req_addr;
        wdata_d = req_wdata;
        beat_d  = 1'b0;
        rdata_d = '0;
        err_d   = is_misaligned(mau_size_e'(req_size), req_addr[1:0]);
        state_d = err_d ? RESP : ISSUE;
      end
      ISSUE: if (!mem.mem_busy) begin
        mem.mem_write_en = we_q;
        mem.mem_read_en  = ~we_q;
        state_d          = WAIT;
      end
      WAIT: begin
        beat_done = we_q ? ~mem.mem_busy : mem.mem_read_avail;
        if (beat_done) begin
          if ((size_q == SIZE_W) && !beat_q) begin
            lo_d    = mem.mem_data_out;
            beat_d  = 1'b1;
            state_d = ISSUE;
          end else begin
            rdata_d = we_q ? 32'h0 : fmt_rdata;
            state_d = RESP;
          end
        end
      end
      RESP: state_d = IDLE;
    endcase
`ifdef MAU_TIMEOUT_EN
    // Watchdog overrides everything, including a strobe that would fire this cycle.
    if (tmo_hit) begin
      mem.mem_write_en = 1'b0;
      mem.mem_read_en  = 1'b0;
      err_d            = 1'b1;
      rdata_d          = '0;
      state_d          = RESP;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      size_q  <= SIZE_B;
      beat_q  <= 1'b0;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      size_q  <= size_d;
      beat_q  <= beat_d;
      we_q    <= we_d;
      uns_q   <= uns_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      lo_q    <= lo_d;
    end
  end

  assign stall     = ((state_q == IDLE) && req_valid) || (state_q == ISSUE) || (state_q == WAIT);
  assign rsp_valid = (state_q == RESP);
  assign rsp_err   = rsp_valid & err_q;
  assign rsp_rdata = rdata_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a small psram responder and strobe/response scoreboards.
module tb_mem_access_unit;
  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        stall, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;

  logic        force_busy = 1'b0;
  logic        inj_avail  = 1'b0;
  logic        mute_avail = 1'b0;
  logic [15:0] rd_arr [0:15];

  logic [1:0]  lat_q;
  logic        pend_q, avail_q;
  logic [3:0]  raddr_q;
  logic [15:0] dout_q;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int hold_left = 0;
  int hold_cfg  = 0;
  bit arm_hold  = 0;
  bit in_txn    = 0;
  bit rsp_seen  = 0;
  int last_rsp_tick;

  logic [42:0] exp_strb [$];
  logic [32:0] exp_rsp  [$];
  int          strb_cyc [$];

  mem_access_unit_if #(.MEM_ADDR_W(22), .BANK_W(1)) bus ();

  mem_access_unit #(.MEM_ADDR_W(22), .BANKS(2), .TIMEOUT_CYCLES(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .stall        (stall),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .mem          (bus)
  );

  always #5 clk = ~clk;

  // Responder: busy for two cycles after any strobe, read data arrives as busy drops.
  always @(posedge clk) begin
    avail_q <= 1'b0;
    if (reset) begin
      lat_q  <= 2'd0;
      pend_q <= 1'b0;
      dout_q <= 16'h0;
    end else if (bus.mem_read_en || bus.mem_write_en) begin
      lat_q   <= 2'd2;
      pend_q  <= bus.mem_read_en;
      raddr_q <= bus.mem_addr[3:0];
    end else if (lat_q != 2'd0) begin
      lat_q <= lat_q - 2'd1;
      if (lat_q == 2'd1 && pend_q) begin
        avail_q <= ~mute_avail;
        dout_q  <= rd_arr[raddr_q];
        pend_q  <= 1'b0;
      end
    end
  end

  assign bus.mem_busy       = (lat_q != 2'd0) | force_busy;
  assign bus.mem_read_avail = avail_q | inj_avail;
  assign bus.mem_data_out   = dout_q;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // One clock: update forced busy just after the edge, then sample DUT outputs.
  task automatic tick();
    logic [42:0] obs;
    @(posedge clk);
    #1;
    cyc++;
    if (hold_left > 0) begin
      hold_left--;
      if (hold_left == 0) force_busy = 1'b0;
    end
    if (arm_hold) begin
      force_busy = 1'b1;
      hold_left  = hold_cfg + 3;
      arm_hold   = 0;
      hold_cfg   = 0;
    end
    #1;
    if (bus.mem_read_en || bus.mem_write_en) begin
      obs = {bus.mem_write_en, bus.mem_read_en, bus.mem_bank_sel, bus.mem_addr,
             bus.mem_write_en ? bus.mem_data_in : 16'h0,
             bus.mem_write_en & bus.mem_write_high_byte,
             bus.mem_write_en & bus.mem_write_low_byte};
      strb_cyc.push_back(cyc);
      if (strb_cyc.size() == 1 && hold_cfg > 0) arm_hold = 1;
      check("strobe_expected", 64'(exp_strb.size() != 0), 64'd1);
      if (exp_strb.size() != 0) check("strobe", 64'(obs), 64'(exp_strb.pop_front()));
    end
    check("stall", 64'(stall), 64'(in_txn && !rsp_valid));
    if (rsp_valid) begin
      check("rsp_expected", 64'(exp_rsp.size() != 0), 64'd1);
      if (exp_rsp.size() != 0) check("rsp", 64'({rsp_err, rsp_rdata}), 64'(exp_rsp.pop_front()));
      rsp_seen = 1;
      in_txn   = 0;
    end
  endtask

  task automatic expect_access(input logic we, input logic [1:0] size, input logic uns,
                               input logic [31:0] addr, input logic [31:0] wdata, input bit tmo);
    logic        mis;
    logic [21:0] ma;
    logic [15:0] d, d0, d1;
    logic        hi, lo;
    logic [7:0]  bsel;
    logic [31:0] rd;
    mis = (size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'b00);
    if (mis) begin
      exp_rsp.push_back({1'b1, 32'h0});
    end else begin
      for (int b = 0; b < ((size == 2'd2) ? 2 : 1); b++) begin
        ma = addr[22:1] + 22'(b);
        d = 16'h0; hi = 1'b0; lo = 1'b0;
        if (we) begin
          hi = 1'b1; lo = 1'b1;
          if (size == 2'd0) begin
            d = {wdata[7:0], wdata[7:0]}; hi = addr[0]; lo = ~addr[0];
          end else if (size == 2'd1 || b == 0) d = wdata[15:0];
          else d = wdata[31:16];
        end
        exp_strb.push_back({we, ~we, addr[23], ma, d, hi, lo});
      end
      d0 = rd_arr[addr[4:1]];
      d1 = rd_arr[addr[4:1] + 4'd1];
      bsel = addr[0] ? d0[15:8] : d0[7:0];
      if (we) rd = 32'h0;
      else if (size == 2'd0) rd = uns ? {24'h0, bsel} : {{24{bsel[7]}}, bsel};
      else if (size == 2'd1) rd = uns ? {16'h0, d0} : {{16{d0[15]}}, d0};
      else rd = {d1, d0};
      exp_rsp.push_back(tmo ? {1'b1, 32'h0} : {1'b0, rd});
    end
  endtask

  task automatic run_access(input string tag, input logic we, input logic [1:0] size, input logic uns,
                            input logic [31:0] addr, input logic [31:0] wdata, input int hold, input bit tmo);
    int t;
    expect_access(we, size, uns, addr, wdata, tmo);
    strb_cyc.delete();
    hold_cfg  = hold;
    rsp_seen  = 0;
    in_txn    = 1;
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr  = addr; req_wdata = wdata;
    #1;
    check({tag, "_stall_req"}, 64'(stall), 64'd1);
    t = 0;
    while (!rsp_seen && t < 100) begin
      tick();
      if (rsp_seen) last_rsp_tick = t;
      if (t == 0) begin
        // Request fields must be ignored once accepted.
        req_valid = 1'b0; req_we = ~we; req_unsigned = ~uns;
        req_addr = $urandom; req_wdata = $urandom; req_size = 2'($urandom_range(0, 2));
      end
      t++;
    end
    check({tag, "_rsp_seen"}, 64'(rsp_seen), 64'd1);
    check({tag, "_strobes_left"}, 64'(exp_strb.size()), 64'd0);
    if (hold > 0 && strb_cyc.size() == 2)
      check({tag, "_beat1_delay"}, 64'(strb_cyc[1] - strb_cyc[0]), 64'(hold + 4));
    exp_strb.delete();
    exp_rsp.delete();
    in_txn = 0;
    tick();
    check({tag, "_rsp_pulse"}, 64'(rsp_valid), 64'd0);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) rd_arr[i] = 16'(16'h1111 * i);
    rd_arr[1] = 16'h80AA;
    rd_arr[6] = 16'h8001;
    rd_arr[8] = 16'hBEEF;
    rd_arr[9] = 16'hDEAD;
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
    tick(); tick();
    check("rst_stall", 64'(stall), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_err", 64'(rsp_err), 64'd0);
    check("rst_rdata", 64'(rsp_rdata), 64'd0);
    check("rst_strobes", 64'({bus.mem_write_en, bus.mem_read_en}), 64'd0);
    reset = 1'b0;
    tick();

    run_access("lb_signed",   1'b0, 2'd0, 1'b0, 32'h0000_0003, 32'h0, 0, 0);
    run_access("lbu",         1'b0, 2'd0, 1'b1, 32'h0000_0003, 32'h0, 0, 0);
    run_access("sw",          1'b1, 2'd2, 1'b0, 32'h0000_0008, 32'h1234_5678, 0, 0);
    run_access("lh_misalign", 1'b0, 2'd1, 1'b0, 32'h0000_0001, 32'h0, 0, 0);
    check("misalign_latency", 64'(last_rsp_tick), 64'd0);
    run_access("lw_busy",     1'b0, 2'd2, 1'b0, 32'h0000_0010, 32'h0, 5, 0);
    run_access("sb_hi",       1'b1, 2'd0, 1'b0, 32'h0000_0005, 32'h0000_00A5, 0, 0);
    run_access("sb_lo",       1'b1, 2'd0, 1'b0, 32'h0000_0006, 32'h0000_003C, 0, 0);
    run_access("sh_bank1",    1'b1, 2'd1, 1'b0, 32'h0080_0006, 32'h0000_CAFE, 0, 0);
    run_access("lh_signed",   1'b0, 2'd1, 1'b0, 32'h0000_000C, 32'h0, 0, 0);
    run_access("lhu",         1'b0, 2'd1, 1'b1, 32'h0000_000C, 32'h0, 0, 0);
    run_access("lw_misalign", 1'b0, 2'd2, 1'b0, 32'h0000_0002, 32'h0, 0, 0);
    run_access("lw_plain",    1'b0, 2'd2, 1'b1, 32'h0000_0010, 32'h0, 0, 0);

    // Reset while waiting for read data, then a stray read_avail.
    expect_access(1'b0, 2'd1, 1'b0, 32'h0000_0020, 32'h0, 0);
    exp_rsp.delete();
    in_txn = 1;
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd1; req_unsigned = 1'b0; req_addr = 32'h20;
    tick();
    req_valid = 1'b0;
    tick();
    reset  = 1'b1;
    in_txn = 0;
    tick();
    check("wait_rst_rsp_valid", 64'(rsp_valid), 64'd0);
    reset = 1'b0;
    inj_avail = 1'b1;
    tick();
    inj_avail = 1'b0;
    tick(); tick();
    check("late_avail_rsp", 64'(rsp_valid), 64'd0);
    check("late_avail_strobes", 64'({bus.mem_write_en, bus.mem_read_en}), 64'd0);
    exp_strb.delete();
    run_access("after_reset", 1'b0, 2'd0, 1'b1, 32'h0000_0002, 32'h0, 0, 0);

`ifdef MAU_TIMEOUT_EN
    mute_avail = 1'b1;
    run_access("timeout", 1'b0, 2'd1, 1'b0, 32'h0000_0024, 32'h0, 0, 1);
    check("timeout_latency", 64'(last_rsp_tick), 64'd17);
    mute_avail = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Load/store bridge between the rv32i core's MA stage and the 16-bit psram controller. Accepts one byte, halfword or word access, splits words into two 16-bit beats, and formats store lanes and load data with sign or zero extension. Raises a stall toward the core until the access completes, and reports misaligned accesses.

Parameters:
MEM_ADDR_W, 22, 16-bit word address width of one psram bank.
BANKS, 2, number of psram banks selectable (BANK_W = max(1, $clog2(BANKS))).
TIMEOUT_CYCLES, 1024, wait-state watchdog limit (used only with the optional feature).

Ports:
clk  input  1  clock
reset  input  1  synchronous active-high reset
req_valid  input  1  core access request
req_we  input  1  1 = store, 0 = load
req_size  input  2  mau_size_e: SIZE_B, SIZE_H, SIZE_W
req_unsigned  input  1  zero-extend loads (LBU/LHU)
req_addr  input  32  byte address
req_wdata  input  32  store data
stall  output  1  hold core pipeline
rsp_valid  output  1  one-cycle completion pulse
rsp_rdata  output  32  formatted load data
rsp_err  output  1  misaligned or timed out, valid with rsp_valid
mem_bank_sel  output  BANK_W  psram bank
mem_addr  output  MEM_ADDR_W  psram 16-bit word address
mem_write_en  output  1  write strobe pulse
mem_read_en  output  1  read strobe pulse
mem_data_in  output  16  write data
mem_write_high_byte  output  1  upper lane enable
mem_write_low_byte  output  1  lower lane enable
mem_busy  input  1  controller busy
mem_read_avail  input  1  read data valid pulse
mem_data_out  input  16  read data

Behaviour:
- Clock is clk. Reset is synchronous and active-high on reset. On reset: state IDLE; stall, rsp_valid, rsp_err, mem_write_en and mem_read_en are 0; rsp_rdata is 0.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE + req_valid: latch the request.
  - Misaligned (H with addr[0]=1, or W with addr[1:0]!=0): go to RESP with err=1 and rdata=0. No memory strobe is issued.
  - Otherwise: go to ISSUE with beat=0.
- ISSUE: when mem_busy=0, pulse exactly one strobe for one cycle, then go to WAIT. While mem_busy=1, hold in ISSUE.
- WAIT:
  - Load beats complete on mem_read_avail.
  - Store beats complete on the first cycle mem_busy=0 after the strobe.
  - If a word access is on beat 0: capture the low half, set beat=1, return to ISSUE.
  - Otherwise go to RESP.
- RESP: rsp_valid=1 for one cycle, rsp_rdata/rsp_err are valid, then IDLE. A new req_valid is not sampled in RESP; there is exactly one bubble cycle.
- stall = (state==IDLE && req_valid) || state==ISSUE || state==WAIT. stall is 0 in RESP.
- Addressing:
  - mem_addr = addr[MEM_ADDR_W:1] + beat.
  - mem_bank_sel = addr[MEM_ADDR_W+1 +: BANK_W].
  - Aligned words never carry.
- Stores:
  - B: data_in = {wdata[7:0], wdata[7:0]}; high lane = addr[0], low lane = ~addr[0].
  - H: data_in = wdata[15:0], both lanes.
  - W: beat0 = wdata[15:0], beat1 = wdata[31:16], both lanes.
- Loads:
  - B: select byte data_out[15:8] when addr[0]=1, else [7:0].
  - H: data_out.
  - W: {beat1, beat0}.
  - B and H are sign-extended unless req_unsigned. rsp_rdata=0 for stores.
- mem_read_avail outside WAIT is ignored.
- Reset mid-access returns to IDLE with no rsp_valid. The psram controller is reset by the same reset.
- Request fields are sampled only at acceptance. Later changes are ignored until RESP.

Optional Feature:
MAU_TIMEOUT_EN
- Defined: a counter runs in ISSUE/WAIT and clears on each state entry. Reaching TIMEOUT_CYCLES forces RESP with rsp_err=1 and rsp_rdata=0.
- Undefined: no counter; the block waits indefinitely.

Decomposition:
- rv32i package gets:
  - mau_size_e (SIZE_B=0, SIZE_H=1, SIZE_W=2);
  - mau_state_e (IDLE, ISSUE, WAIT, RESP).
- Sub-module mau_load_format is combinational. It maps size, unsigned, addr[0], the captured low half and mem_data_out to rsp_rdata.

Test Plan:
- Load byte, addr 0x0000_0003, data_out 0x80AA, signed → mem_addr 0x000001, rsp_rdata 0xFFFF_FF80; with req_unsigned → 0x0000_0080.
- Store word 0x1234_5678, addr 0x0000_0008 → two strobes: addr 0x4 with 0x5678, then addr 0x5 with 0x1234, both lanes set. stall is high until RESP, rsp_err=0.
- Load halfword, addr 0x0000_0001 → no strobe, rsp_valid one cycle after acceptance, rsp_err=1, rsp_rdata 0.
- Load word with mem_busy held high 5 cycles before beat 1 → strobe is delayed 5 cycles, rsp_rdata = {beat1, beat0} exact. The bench checks that only one strobe is issued per beat.
- reset asserted in WAIT → next cycle IDLE, stall=0, no rsp_valid. A late mem_read_avail is ignored.
- MAU_TIMEOUT_EN with TIMEOUT_CYCLES=16 and read_avail never arriving → rsp_valid with rsp_err=1 after 16 WAIT/ISSUE cycles.
